// File: rtl/multi_clk_div_gen.sv
// Multi-channel programmable clock divider: each channel turns the source clock
// into a registered divided clock whose ratio can be changed without glitches.
module multi_clk_div_gen #(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic [NUM_CH-1:0]       cfg_load,
  output logic [NUM_CH-1:0]       clk_p,
  output logic [NUM_CH-1:0]       clk_n,
  output logic [NUM_CH-1:0]       ch_active,
  output logic [NUM_CH-1:0]       edge_tick
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] MIN_N = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

  // Handshake: none. ch_en is a level sampled only in IDLE or at a period
  // boundary; cfg_load is a single-cycle strobe qualifying div_ratio.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] n_act_q, n_act_d;
    logic [DIV_W-1:0] n_pend_q, n_pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_p_q, clk_p_d;
    logic             clk_n_q;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] ratio_raw;
    logic [DIV_W-1:0] ratio_cl;
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] cnt_inc;
    logic             boundary;

    assign ratio_raw = div_ratio[i*DIV_W +: DIV_W];
    // Ratios below 2 cannot produce both a high and a low phase.
    assign ratio_cl  = (ratio_raw < MIN_N) ? MIN_N : ratio_raw;
    assign half      = n_act_q >> 1;
    assign cnt_inc   = cnt_q + ONE;
    assign boundary  = (cnt_q == (n_act_q - ONE));

    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      n_act_d    = n_act_q;
      n_pend_d   = n_pend_q;
      pend_vld_d = pend_vld_q;
      clk_p_d    = clk_p_q;
      tick_d     = 1'b0;
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          clk_p_d = 1'b0;
          if (cfg_load[i]) n_act_d = ratio_cl;
          if (ch_en[i]) begin
            state_d = RUN;
            clk_p_d = 1'b1;
            tick_d  = 1'b1;
          end
        end
        RUN: begin
          if (!boundary) begin
            cnt_d   = cnt_inc;
            clk_p_d = (cnt_inc < half);
            if (cfg_load[i]) begin
              n_pend_d   = ratio_cl;
              pend_vld_d = 1'b1;
            end
          end else begin
            // A load landing on the boundary beats any older pending value.
            if (cfg_load[i])     n_act_d = ratio_cl;
            else if (pend_vld_q) n_act_d = n_pend_q;
            pend_vld_d = 1'b0;
            cnt_d      = '0;
            if (ch_en[i]) begin
              clk_p_d = 1'b1;
              tick_d  = 1'b1;
            end else begin
              state_d = IDLE;
              clk_p_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          clk_p_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        n_act_q    <= DEF_N;
        n_pend_q   <= DEF_N;
        pend_vld_q <= 1'b0;
        clk_p_q    <= 1'b0;
        clk_n_q    <= 1'b1;
        tick_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        n_act_q    <= n_act_d;
        n_pend_q   <= n_pend_d;
        pend_vld_q <= pend_vld_d;
        clk_p_q    <= clk_p_d;
        clk_n_q    <= ~clk_p_d;
        tick_q     <= tick_d;
      end
    end

    assign clk_p[i]     = clk_p_q;
    assign clk_n[i]     = clk_n_q;
    assign ch_active[i] = (state_q == RUN);
    assign edge_tick[i] = tick_q;
  end

endmodule

// File: doc/multi_clk_div_gen.md
MULTI_CLK_DIV_GEN -- requirements
Module: multi_clk_div_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divided-clock channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 8: width of each channel's divide-ratio field.
REQ-003 SHALL have parameter DEF_DIV, default 4: divide ratio in force after reset (>=2).
REQ-004 SHALL have port clk  input  1: single source clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-006 SHALL have port ch_en  input  NUM_CH: per-channel run request, level.
REQ-007 SHALL have port div_ratio  input  NUM_CH*DIV_W: channel i ratio N in bits [i*DIV_W +: DIV_W].
REQ-008 SHALL have port cfg_load  input  NUM_CH: one-cycle pulse capturing div_ratio for channel i.
REQ-009 SHALL have port clk_p  output  NUM_CH: divided clock, true phase, registered.
REQ-010 SHALL have port clk_n  output  NUM_CH: divided clock, complement, registered, always ~clk_p.
REQ-011 SHALL have port ch_active  output  NUM_CH: channel i is in RUN.
REQ-012 SHALL have port edge_tick  output  NUM_CH: one-cycle pulse in the cycle clk_p[i] goes high.

Function
REQ-013 SHALL implement per channel a two-state FSM IDLE/RUN, a cycle counter cnt (DIV_W bits), an active ratio N_act and a pending ratio N_pend with valid flag.
REQ-014 SHALL clamp captured ratios of 0 or 1 to 2; all other values used unmodified.
REQ-015 SHALL define high-phase length H = floor(N_act/2); period = N_act clk cycles; low phase = N_act - H (odd N: low phase one cycle longer).
REQ-016 IDLE: clk_p=0, clk_n=1, ch_active=0, cnt=0.
REQ-017 IDLE with ch_en=1: next cycle state RUN, cnt=0, clk_p=1, edge_tick=1, ch_active=1 (start latency 1 cycle).
REQ-018 RUN, cnt < N_act-1: cnt<=cnt+1, clk_p<=(cnt+1 < H), edge_tick=0.
REQ-019 RUN, cnt = N_act-1 (period boundary) with ch_en=1: cnt<=0, clk_p<=1, edge_tick<=1, N_act<=N_pend if valid, valid cleared.
REQ-020 RUN, period boundary with ch_en=0: state IDLE, clk_p stays 0, ch_active<=0; no truncated period, no glitch.
REQ-021 ch_en deasserted then reasserted before the boundary SHALL be ignored (seamless running).
REQ-022 cfg_load while IDLE: N_act updated directly; takes effect on next start.
REQ-023 cfg_load while RUN: written to N_pend (overwrites earlier pending value); applied only at next boundary.
REQ-024 cfg_load coincident with boundary or with IDLE->RUN start: new value governs the period beginning in that transition.
REQ-025 Channels SHALL be fully independent; no cross-channel phase relation except via identical stimulus timing.

Reset
REQ-026 rst_n=0 at a clk edge SHALL force every channel: IDLE, cnt=0, N_act=DEF_DIV, pending invalid, clk_p=0, clk_n=1, ch_active=0, edge_tick=0.
REQ-027 Reset mid-period SHALL abort the period immediately (reset overrides REQ-020).
REQ-028 First start after release needs ch_en=1 sampled with rst_n=1; outputs never toggle while rst_n=0.

Verification
REQ-029 Reset then ch_en[0]=1, no load -> clk_p[0] high 2 / low 2 cycles (N=4), edge_tick every 4 cycles starting 1 cycle after ch_en.
REQ-030 cfg_load[1] with ratio 5 while IDLE, start -> high 2 / low 3, period 5; ratio 0 -> behaves as 2 (high 1 / low 1).
REQ-031 Channel running N=4, cfg_load ratio 8 at cnt=1 -> current period completes at 4 cycles, next period 8 cycles (high 4), no short pulse.
REQ-032 Drop ch_en at cnt=0 with N=6 -> clk_p completes 3 high + 3 low, ch_active falls at boundary, clk_p stays 0; pulse ch_en low for 2 cycles mid-period -> no interruption.
REQ-033 Assert rst_n=0 while clk_p=1 mid-period -> next cycle clk_p=0, clk_n=1, ch_active=0; N_act back to 4.
REQ-034 All 4 channels with ratios 2,3,4,255 simultaneously -> each period/duty independently correct; clk_n == ~clk_p every cycle.
